// File: rtl/match_ctrl.sv
// Match controller for a two-player paddle game: serve timing, scoring,
// point flash and game-over handling, all paced by a game-rate tick.
module match_ctrl #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SERVE_TICKS = 1500,
  parameter int unsigned FLASH_TICKS = 750
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       out_left,
  input  logic       out_right,
  output logic       serve,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       flash,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SCORE_W = 4;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SERVE_WAIT = 3'd1;
  localparam logic [2:0] S_PLAY       = 3'd2;
  localparam logic [2:0] S_POINT      = 3'd3;
  localparam logic [2:0] S_OVER       = 3'd4;

  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS - 1);
  localparam logic [CNT_W-1:0]   FLASH_LOAD = CNT_W'(FLASH_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

  logic [CNT_W-1:0]   cnt;
  logic               start_q;
  logic               out_left_q;
  logic               out_right_q;

  logic               start_edge;
  logic               left_edge;
  logic               right_edge;

  logic [2:0]         state_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [SCORE_W-1:0] p1_d;
  logic [SCORE_W-1:0] p2_d;
  logic               dir_d;
  logic               winner_d;
  logic               serve_d;

  // Rising-edge detection against last cycle's input levels
  assign start_edge = start & ~start_q;
  assign left_edge  = out_left & ~out_left_q;
  assign right_edge = out_right & ~out_right_q;

  // Next-state and next-output decode
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    p1_d     = score_p1;
    p2_d     = score_p2;
    dir_d    = serve_dir;
    winner_d = winner;
    serve_d  = 1'b0;
    case (state)
      S_IDLE: begin
        p1_d = '0;
        p2_d = '0;
        if (start_edge) begin
          cnt_d   = SERVE_LOAD;
          dir_d   = 1'b0;
          state_d = S_SERVE_WAIT;
        end
      end
      S_SERVE_WAIT: begin
        if (tick) begin
          if (cnt == '0) begin
            serve_d = 1'b1;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (left_edge && right_edge) begin
          // Simultaneous exits: no score, serve direction kept
          cnt_d   = FLASH_LOAD;
          state_d = S_POINT;
        end else if (left_edge) begin
          p2_d  = score_p2 + SCORE_W'(1);
          dir_d = 1'b0;
          if (p2_d == WIN) begin
            winner_d = 1'b1;
            state_d  = S_OVER;
          end else begin
            cnt_d   = FLASH_LOAD;
            state_d = S_POINT;
          end
        end else if (right_edge) begin
          p1_d  = score_p1 + SCORE_W'(1);
          dir_d = 1'b1;
          if (p1_d == WIN) begin
            winner_d = 1'b0;
            state_d  = S_OVER;
          end else begin
            cnt_d   = FLASH_LOAD;
            state_d = S_POINT;
          end
        end
      end
      S_POINT: begin
        if (tick) begin
          if (cnt == '0) begin
            cnt_d   = SERVE_LOAD;
            state_d = S_SERVE_WAIT;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
      end
      S_OVER: begin
        if (start_edge) begin
          p1_d    = '0;
          p2_d    = '0;
          dir_d   = 1'b0;
          cnt_d   = SERVE_LOAD;
          state_d = S_SERVE_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter, edge history and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      score_p1    <= '0;
      score_p2    <= '0;
      serve       <= 1'b0;
      serve_dir   <= 1'b0;
      flash       <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      start_q     <= 1'b0;
      out_left_q  <= 1'b0;
      out_right_q <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      score_p1    <= p1_d;
      score_p2    <= p2_d;
      serve       <= serve_d;
      serve_dir   <= dir_d;
      flash       <= (state_d == S_POINT) || (state_d == S_OVER);
      game_over   <= (state_d == S_OVER);
      winner      <= winner_d;
      start_q     <= start;
      out_left_q  <= out_left;
      out_right_q <= out_right;
    end
  end

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl: a phase/ticks-remaining reference model
// predicts every change of the output vector together with the cycle it
// should appear on; a monitor checks each DUT output change against it.
module tb_match_ctrl;

  localparam int WIN = 2;
  localparam int STK = 3;
  localparam int FTK = 4;

  localparam int P_IDLE  = 0;
  localparam int P_SW    = 1;
  localparam int P_PLAY  = 2;
  localparam int P_POINT = 3;
  localparam int P_OVER  = 4;

  typedef struct packed {
    logic [15:0] snap;
    int          cyc;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset, tick, start, out_left, out_right;
  logic       serve, serve_dir, flash, game_over, winner;
  logic [3:0] score_p1, score_p2;
  logic [2:0] state;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t exp_q[$];

  // Reference model state
  int          m_phase = P_IDLE;
  int          m_left  = 0;
  int          m_s1    = 0;
  int          m_s2    = 0;
  bit          m_dir   = 1'b0;
  bit          m_win   = 1'b0;
  bit          m_serve = 1'b0;
  bit          p_st = 1'b0, p_ol = 1'b0, p_or = 1'b0;
  logic [15:0] m_last = 'x;
  logic [15:0] d_last = 'x;

  match_ctrl #(
    .WIN_SCORE  (WIN),
    .SERVE_TICKS(STK),
    .FLASH_TICKS(FTK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start    (start),
    .out_left (out_left),
    .out_right(out_right),
    .serve    (serve),
    .serve_dir(serve_dir),
    .score_p1 (score_p1),
    .score_p2 (score_p2),
    .flash    (flash),
    .game_over(game_over),
    .winner   (winner),
    .state    (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Predict the outputs visible after the next clock edge
  task automatic model_step(input bit r, input bit tk, input bit st,
                            input bit ol, input bit orr, input int stamp);
    bit          se, le, re;
    logic [15:0] s;
    rec_t        e;
    se = st & ~p_st;
    le = ol & ~p_ol;
    re = orr & ~p_or;
    m_serve = 1'b0;
    if (r) begin
      m_phase = P_IDLE; m_left = 0; m_s1 = 0; m_s2 = 0;
      m_dir = 1'b0; m_win = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: if (se) begin m_phase = P_SW; m_left = STK; m_dir = 1'b0; end
        P_SW: if (tk) begin
          m_left--;
          if (m_left == 0) begin m_serve = 1'b1; m_phase = P_PLAY; end
        end
        P_PLAY: begin
          if (le && re) begin
            m_phase = P_POINT; m_left = FTK;
          end else if (le || re) begin
            if (le) begin m_s2++; m_dir = 1'b0; end
            else    begin m_s1++; m_dir = 1'b1; end
            if (m_s1 == WIN || m_s2 == WIN) begin
              m_phase = P_OVER; m_win = le;
            end else begin
              m_phase = P_POINT; m_left = FTK;
            end
          end
        end
        P_POINT: if (tk) begin
          m_left--;
          if (m_left == 0) begin m_phase = P_SW; m_left = STK; end
        end
        default: if (se) begin
          m_s1 = 0; m_s2 = 0; m_dir = 1'b0; m_phase = P_SW; m_left = STK;
        end
      endcase
    end
    p_st = r ? 1'b0 : st;
    p_ol = r ? 1'b0 : ol;
    p_or = r ? 1'b0 : orr;
    s = {3'(m_phase), m_serve, m_dir, 4'(m_s1), 4'(m_s2),
         (m_phase == P_POINT || m_phase == P_OVER), (m_phase == P_OVER), m_win};
    if (s !== m_last) begin
      e.snap = s;
      e.cyc  = stamp;
      exp_q.push_back(e);
      m_last = s;
    end
  endtask

  // Drive one clock cycle of inputs
  task automatic cycle(input bit r, input bit tk, input bit st,
                       input bit ol, input bit orr);
    reset = r; tick = tk; start = st; out_left = ol; out_right = orr;
    model_step(r, tk, st, ol, orr, cyc + 1);
    @(posedge clk);
    #1;
  endtask

  // Tick along with quiet inputs until the model reaches a phase
  task automatic run_until(input int ph, input int limit);
    int n;
    n = 0;
    while (m_phase != ph && n < limit) begin
      cycle(1'b0, n[0], 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (m_phase != ph) begin
      n_bad++;
      $display("FAIL run_until phase got=%0d required=%0d", m_phase, ph);
    end
  endtask

  // Monitor: every change of the DUT output vector is one transaction
  always @(negedge clk) begin
    logic [15:0] snap;
    rec_t        e;
    snap = {state, serve, serve_dir, score_p1, score_p2, flash, game_over, winner};
    if (snap !== d_last) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, snap);
      end else begin
        e = exp_q.pop_front();
        if (e.snap !== snap || e.cyc != cyc) begin
          n_bad++;
          $display("FAIL transaction got=%h@%0d required=%h@%0d", snap, cyc, e.snap, e.cyc);
        end
      end
      d_last = snap;
    end
  end

  initial begin
    bit lo, lr;
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Serve timing: tick every 4 cycles
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, (i % 4) == 3, 1'b0, 1'b0, 1'b0);
    run_until(P_PLAY, 50);
    // Player 1 scores
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_until(P_SW, 50);
    run_until(P_PLAY, 50);
    // Draw
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_until(P_PLAY, 100);
    // Held out_left level: a single increment only
    for (int i = 0; i < 100; i++) cycle(1'b0, (i % 3) == 0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_until(P_PLAY, 100);
    // Winning point, ignored extra edge, restart
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_until(P_PLAY, 100);
    // Reset in the middle of POINT
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Randomized play
    lo = 1'b0;
    lr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) lo = ~lo;
      if ($urandom_range(0, 7) == 0) lr = ~lr;
      if ($urandom_range(0, 39) == 0) begin lo = 1'b1; lr = 1'b1; end
      cycle($urandom_range(0, 599) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 29) == 0, lo, lr);
    end
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expected got=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 9, points needed to win a match; legal range 1..15.
REQ-002 Parameter SERVE_TICKS, default 1500, tick count from entering SERVE_WAIT to the serve pulse; legal range 1..65535.
REQ-003 Parameter FLASH_TICKS, default 750, tick count spent in POINT after a point; legal range 1..65535.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tick  input  1  one-cycle game-rate enable pulse; all timing counters advance only when tick=1.
REQ-007 start  input  1  debounced start button, level.
REQ-008 out_left  input  1  ball left the field past the left paddle, level.
REQ-009 out_right  input  1  ball left the field past the right paddle, level.
REQ-010 serve  output  1  one-cycle pulse that launches the ball.
REQ-011 serve_dir  output  1  0 = serve toward player 1 (left), 1 = toward player 2 (right); stable while serve=1.
REQ-012 score_p1  output  4  player 1 score.
REQ-013 score_p2  output  4  player 2 score.
REQ-014 flash  output  1  background highlight request.
REQ-015 game_over  output  1  high while in OVER.
REQ-016 winner  output  1  0 = player 1, 1 = player 2; valid only while game_over=1.
REQ-017 state  output  3  encoded FSM state: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, OVER=4.

Function
REQ-018 Rising edges of start, out_left and out_right are detected each clk cycle against registered previous values; edges are acted on only in the states named below and are otherwise discarded.
REQ-019 IDLE: scores are held at 0; a start rising edge loads the counter with SERVE_TICKS-1, sets serve_dir=0 and enters SERVE_WAIT.
REQ-020 SERVE_WAIT: on each tick with counter=0, serve is asserted for exactly that cycle and the FSM enters PLAY; on any other tick the counter decrements by 1.
REQ-021 PLAY, out_left edge only: score_p2 increments by 1 and serve_dir is set to 0.
REQ-022 PLAY, out_right edge only: score_p1 increments by 1 and serve_dir is set to 1.
REQ-023 PLAY, both edges in the same cycle: scoring is a draw, neither score changes, serve_dir is unchanged, and the FSM enters POINT.
REQ-024 After a scoring increment, if the new score equals WIN_SCORE, the FSM enters OVER with winner set to the scorer; otherwise it enters POINT; scores never exceed WIN_SCORE.
REQ-025 Entering POINT loads the counter with FLASH_TICKS-1; flash=1 throughout POINT; a tick with counter=0 reloads SERVE_TICKS-1 and enters SERVE_WAIT; any other tick decrements the counter.
REQ-026 OVER: flash=1 and game_over=1; scores and winner are held; a start rising edge clears both scores, sets serve_dir=0, loads SERVE_TICKS-1 and enters SERVE_WAIT.
REQ-027 Start edges in SERVE_WAIT, PLAY and POINT are ignored; out edges outside PLAY are ignored.
REQ-028 Counter width is 16 bits; the counter never underflows, since the transition is taken at 0.
REQ-029 A tick coincident with a state-entry cycle does not count toward the new state's delay; the counter load takes priority.
REQ-030 All outputs are registered; serve and every state transition become visible on the cycle after the causing edge or tick.

Reset
REQ-031 While reset=1 at a clk edge: state=IDLE, counter=0, score_p1=0, score_p2=0, serve=0, serve_dir=0, flash=0, game_over=0, winner=0, and all edge-detect history registers=0.
REQ-032 Reset takes priority over every other input in any state, including mid-countdown and during the serve cycle.

Verification
REQ-033 Serve timing: SERVE_TICKS=3; reset; start edge; tick every 4 cycles -> serve=1 for exactly 1 cycle on the 3rd tick after entering SERVE_WAIT, with serve_dir=0, then state=2.
REQ-034 Scoring: in PLAY, pulse out_right -> score_p1=1, state=3, flash=1; after FLASH_TICKS ticks -> state=1 with serve_dir=1.
REQ-035 Draw: in PLAY, assert out_left and out_right in the same cycle -> scores unchanged, state=3.
REQ-036 Win: WIN_SCORE=2; two out_left edges across two rallies -> score_p2=2, state=4, game_over=1, winner=1; an extra out_left edge leaves score_p2 at 2; a start edge -> scores 0, state=1.
REQ-037 Reset mid-operation: assert reset during POINT with score_p1=1 -> next cycle all outputs match REQ-031 and state=0.
REQ-038 Held level: out_left held high for 100 cycles in PLAY -> exactly one increment.
